// File: rtl/srambank_pkg.sv
// srambank_pkg: shared geometry constants and bank decode helper for the SRAM bank front-end.
package srambank_pkg;
  localparam int NBANKS  = 4;
  localparam int BANK_AW = 10;
  localparam int DW      = 16;
  localparam int BW      = $clog2(NBANKS);
  localparam int ADDR_W  = BANK_AW + BW;
  typedef logic [BW-1:0] bank_idx_t;
  function automatic logic [NBANKS-1:0] onehot_bank(input bank_idx_t idx);
    return NBANKS'(1) << idx;
  endfunction
endpackage

// File: rtl/srambank_rsp_fifo.sv
// srambank_rsp_fifo: first-word-fall-through response FIFO with occupancy count.
module srambank_rsp_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [DW-1:0]                data_i,
  input  logic                         pop_i,
  output logic [DW-1:0]                data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_i) rd_q <= inc(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/srambank_req_ctrl.sv
// srambank_req_ctrl: request decode onto shared SRAM bank lines and in-order read response return.
module srambank_req_ctrl
  import srambank_pkg::*;
#(
  parameter int RSP_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 req_write,
  input  logic [DW-1:0]        req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_data,
  output logic [BANK_AW-1:0]   bank_address,
  output logic [DW-1:0]        bank_wd,
  output logic [NBANKS-1:0]    bank_sel,
  output logic                 bank_read,
  output logic                 bank_write,
  input  logic [NBANKS*DW-1:0] bank_dataout
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic          fire, rd_pend_q, rd_pend_d;
  bank_idx_t     req_bank, rd_bank_q, rd_bank_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  // An in-flight read already owns a FIFO slot, so it counts toward occupancy.
  assign occupancy    = {1'b0, fifo_count} + (CW+1)'(rd_pend_q);
  assign req_ready    = reset_n && (occupancy < (CW+1)'(RSP_DEPTH));
  assign fire         = req_valid && req_ready;
  assign req_bank     = req_addr[ADDR_W-1:BANK_AW];
  assign bank_sel     = fire ? onehot_bank(req_bank) : '0;
  assign bank_read    = fire && !req_write;
  assign bank_write   = fire && req_write;
  assign bank_address = req_addr[BANK_AW-1:0];
  assign bank_wd      = req_wdata;
  assign rsp_valid    = fifo_count != '0;
  always_comb begin
    rd_pend_d = fire && !req_write;
    rd_bank_d = rd_pend_d ? req_bank : rd_bank_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_bank_q <= rd_bank_d;
    end
  end
  srambank_rsp_fifo #(.DW(DW), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_ni  (reset_n),
    .push_i  (rd_pend_q),
    .data_i  (bank_dataout[int'(rd_bank_q)*DW +: DW]),
    .pop_i   (rsp_valid && rsp_ready),
    .data_o  (rsp_data),
    .count_o (fifo_count)
  );
endmodule

// File: tb/tb_srambank_req_ctrl.sv
// tb_srambank_req_ctrl: bank environment, flat-memory reference model and response scoreboard.
module tb_srambank_req_ctrl;
  import srambank_pkg::*;
  logic                 clk = 0;
  logic                 reset_n;
  logic                 req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]    req_addr;
  logic [DW-1:0]        req_wdata;
  logic                 rsp_valid, rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic [BANK_AW-1:0]   bank_address;
  logic [DW-1:0]        bank_wd;
  logic [NBANKS-1:0]    bank_sel;
  logic                 bank_read, bank_write;
  logic [NBANKS*DW-1:0] bank_dataout;
  int checks = 0;
  int errors = 0;
  logic [15:0] seed;
  logic [DW-1:0] ref_mem [1 << ADDR_W];
  logic [DW-1:0] exp_q [$];
  bit   [DW-1:0] bmem [NBANKS][1 << BANK_AW];
  bit            bwr  [NBANKS][1 << BANK_AW];
  bit   [DW-1:0] dout [NBANKS];

  srambank_req_ctrl #(.RSP_DEPTH(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bank_address(bank_address), .bank_wd(bank_wd), .bank_sel(bank_sel),
    .bank_read(bank_read), .bank_write(bank_write), .bank_dataout(bank_dataout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return 16'(a * 40503) ^ seed;
  endfunction

  // Behavioural banks: write on the edge, registered dataout one cycle later.
  always @(posedge clk)
    for (int i = 0; i < NBANKS; i++)
      if (bank_sel[i]) begin
        if (bank_write) begin
          bmem[i][bank_address] <= bank_wd;
          bwr[i][bank_address]  <= 1'b1;
        end
        if (bank_read)
          dout[i] <= bwr[i][bank_address] ? bmem[i][bank_address] : init_val(i * (1 << BANK_AW) + int'(bank_address));
      end
  always_comb
    for (int i = 0; i < NBANKS; i++) bank_dataout[i*DW +: DW] = dout[i];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      chk("no_push_when_full", 32'(dut.rd_pend_q && int'(dut.fifo_count) == 3), 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got %h expected none at %0t", rsp_data, $time);
        end else chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one request at a negedge; the reference memory is updated only if it fires.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DW-1:0] d, output logic fired);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
    #1;
    fired = req_ready;
    chk("bank_sel", 32'(bank_sel), fired ? 32'(1 << a[ADDR_W-1:BANK_AW]) : 0);
    chk("bank_strobes", {30'b0, bank_read, bank_write}, fired ? (wr ? 32'd1 : 32'd2) : 32'd0);
    if (fired) begin
      chk("bank_address", 32'(bank_address), 32'(a % (1 << BANK_AW)));
      if (wr) begin
        chk("bank_wd", 32'(bank_wd), 32'(d));
        ref_mem[a] = d;
      end else exp_q.push_back(ref_mem[a]);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
    logic f = 0;
    for (int n = 0; n < 50 && !f; n++) issue(wr, a, d, f);
    if (!f) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    req_valid = 0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 0; rsp_ready = 1;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic f;
    int n;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    int n;
    seed = 16'($urandom);
    for (int a = 0; a < (1 << ADDR_W); a++) ref_mem[a] = init_val(a);
    reset_n = 0; req_valid = 1; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_bank_read", 32'(bank_read), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    req_valid = 0;
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("post_reset_ready", 32'(req_ready), 1);
    @(negedge clk);
    // Write then read with explicit latency check.
    send(1, 12'h005, 16'hA5A5);
    send(0, 12'h005, 16'h0);
    chk("lat_not_yet", 32'(rsp_valid), 0);
    idle();
    chk("lat_valid", 32'(rsp_valid), 1);
    chk("lat_data", 32'(rsp_data), 32'hA5A5);
    drain();
    // One write and read per bank.
    for (int b = 0; b < 4; b++) send(1, 12'(b << 10), 16'(16'h1111 * (b + 1)));
    for (int b = 0; b < 4; b++) send(0, 12'(b << 10), 16'h0);
    drain();
    // Back-to-back reads with a ready consumer.
    for (int k = 0; k < 16; k++) begin
      if (k >= 2) chk("b2b_rsp_valid", 32'(rsp_valid), 1);
      issue(0, 12'($urandom), 16'h0, f);
      chk("b2b_fired", 32'(f), 1);
    end
    req_valid = 0;
    chk("b2b_tail_valid", 32'(rsp_valid), 1);
    drain();
    // Backpressure: only three reads accepted.
    rsp_ready = 0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      issue(0, 12'($urandom), 16'h0, f);
      n += int'(f);
    end
    req_valid = 0;
    chk("bp_accepted", 32'(n), 3);
    chk("bp_ready_low", 32'(req_ready), 0);
    drain();
    #1;
    chk("bp_ready_resumed", 32'(req_ready), 1);
    @(negedge clk);
    // Read-write-read ordering on one address.
    send(1, 12'h123, 16'h0BAD);
    send(0, 12'h123, 16'h0);
    send(1, 12'h123, 16'hBEEF);
    send(0, 12'h123, 16'h0);
    drain();
    // Reset with two queued responses and one in flight.
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) send(0, 12'($urandom), 16'h0);
    req_valid = 1; req_write = 0;
    reset_n = 0;
    #1;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mid_ready", 32'(req_ready), 0);
    chk("rst_mid_sel", 32'(bank_sel), 0);
    exp_q.delete();
    req_valid = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    rsp_ready = 1;
    #1;
    chk("rst_rel_ready", 32'(req_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_stale", 32'(rsp_valid), 0);
    end
    // Randomised mix with random consumer backpressure and colliding addresses.
    for (int k = 0; k < 400; k++) begin
      rsp_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 4) == 0) idle();
      else issue(1'($urandom), {2'($urandom), 7'b0, 3'($urandom)}, 16'($urandom), f);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/srambank_req_ctrl.md
Name: srambank_req_ctrl

Overview:
- Request front-end and response return stage for a group of NBANKS srambank_256x4x16_6t122 instances.
- Accepts a valid/ready request stream with a flat word address.
- Decodes the upper address bits into one-hot bank selects and drives the shared bank address, data and strobe lines.
- Captures the 1-cycle-latency bank dataout for reads into a small response FIFO with valid/ready backpressure.

Parameters:
- NBANKS, 4, number of attached banks (power of 2).
- BANK_AW, 10, word address width inside one bank.
- DW, 16, data width.
- RSP_DEPTH, 3, response FIFO entries (minimum 3 for full read throughput).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_addr  in  BANK_AW+log2(NBANKS)  word address; the upper bits select the bank.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DW  read data, in request order.
- bank_address  out  BANK_AW  to every bank's ADDRESS.
- bank_wd  out  DW  to every bank's wd.
- bank_sel  out  NBANKS  one-hot banksel.
- bank_read  out  1  shared read strobe.
- bank_write  out  1  shared write strobe.
- bank_dataout  in  NBANKS*DW  concatenated bank dataout; bank i occupies bits [i*DW +: DW].

Behaviour:
- fire = req_valid & req_ready.
- Bank drive is combinational from the request, so the banks sample it on the same edge:
  - bank_sel = fire ? onehot(req_addr[MSBs]) : 0.
  - bank_read = fire & ~req_write.
  - bank_write = fire & req_write.
  - bank_address = req_addr[BANK_AW-1:0] and bank_wd = req_wdata, both don't-care when not firing.
- Outstanding-read register: on a read fire, rd_pend <= 1 and rd_bank <= the bank index; otherwise rd_pend <= 0.
- Capture: when rd_pend = 1, the bank_dataout slice for rd_bank is pushed into the response FIFO that cycle. Read latency is request fire at edge N, response visible at rsp_valid after edge N+1.
- Writes produce no response and impose no ordering delay.
- req_ready = (fifo_count + rd_pend) < RSP_DEPTH.
  - It is registered-state only: no combinational path from rsp_ready or req_valid.
  - The same rule applies to reads and writes.
- FIFO:
  - First-word-fall-through; rsp_valid = (fifo_count != 0) and rsp_data = head entry.
  - Pop when rsp_valid & rsp_ready.
  - Push and pop in the same cycle are allowed: count is unchanged and order is preserved.
  - Pointers wrap modulo RSP_DEPTH.
  - Push when full is impossible by construction; the bench asserts it never happens.
- Throughput:
  - With rsp_ready held at 1, back-to-back reads are accepted every cycle; steady state is count = 1, rd_pend = 1.
  - With rsp_ready = 0, at most RSP_DEPTH reads are accepted, then req_ready drops.
- Read and write are mutually exclusive per request by construction, so the bank never sees both strobes.
- A read following a write to the same address returns the new data (bank write has completed by the read edge).
- Reset (async assert, sync-safe deassert done externally):
  - fifo_count = 0, pointers = 0, rd_pend = 0, rd_bank = 0.
  - rsp_valid = 0, rsp_data = 0 (storage cleared).
  - req_ready = 1 once out of reset.
  - Reset asserted mid-operation drops any in-flight read and all queued responses.
  - Bank strobes are 0 during reset because req_ready is forced 0 while reset_n = 0.

Decomposition:
- Package srambank_pkg holds:
  - constants NBANKS, BANK_AW, DW, ADDR_W = BANK_AW + $clog2(NBANKS);
  - typedef bank_idx_t;
  - a function onehot_bank(idx).
- One sub-module, srambank_rsp_fifo: parameterised FWFT FIFO (DW, RSP_DEPTH) with push, pop, count and async active-low reset.
- Decode, rd_pend tracking and the ready logic stay in the top.

Test Plan:
- Write 0xA5A5 to addr 0x005, then read addr 0x005 -> bank_sel = 0001 on both requests; rsp_data = 0xA5A5 is valid one cycle after the read fire.
- Write 0x1111/0x2222/0x3333/0x4444 to addr 0x000/0x400/0x800/0xC00, then read each back -> bank_sel is 0001/0010/0100/1000 in turn; responses return in order 0x1111..0x4444.
- rsp_ready = 1 with 16 back-to-back reads -> req_ready stays 1, 16 responses arrive on consecutive cycles, no bubbles.
- rsp_ready = 0 with reads issued continuously -> exactly 3 accepted, then req_ready = 0. Raising rsp_ready drains 3 responses in order, after which acceptance resumes.
- Read then write then read to the same addr (old 0x0BAD, new 0xBEEF) -> responses are 0x0BAD then 0xBEEF.
- Assert reset_n = 0 with 2 responses queued and 1 read in flight -> rsp_valid = 0 immediately and req_ready = 0. After release: count = 0, req_ready = 1, and no stale response appears.
